// File: rtl/host_config_loader_pkg.sv
// Shared types and defaults for the host configuration loader.
// Frames are assembled word-serially in a shadow register, then committed atomically.
package host_config_loader_pkg;

  localparam int unsigned HCfgWDefault = 256;

  localparam int unsigned DataWDefault = 32;

  typedef enum logic [0:0] {
    StFill = 1'b0,
    StPend = 1'b1
  } state_e;

  function automatic int unsigned num_words(int unsigned cfg_w, int unsigned data_w);
    return (cfg_w + data_w - 1) / data_w;
  endfunction

  // Index width for n slots; one bit minimum, so single-word frames still get a port.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/host_config_loader_if.sv
// Host stream, array handshake and configuration outputs of the loader.
interface host_config_loader_if
  import host_config_loader_pkg::*;
#(
  parameter int unsigned H_C_W  = HCfgWDefault,
  parameter int unsigned DATA_W = DataWDefault
);
  localparam int unsigned NUM_WORDS = num_words(H_C_W, DATA_W);
  localparam int unsigned IDX_W     = idx_width(NUM_WORDS);

  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              host_abort;
  logic              array_busy;
  logic [H_C_W-1:0]  Host_Config;
  logic              cfg_update;
  logic [IDX_W-1:0]  fill_idx;
  logic [15:0]       cfg_count;

  modport master (
    output host_valid, host_data, host_abort, array_busy,
    input  host_ready, Host_Config, cfg_update, fill_idx, cfg_count
  );

  modport slave (
    input  host_valid, host_data, host_abort, array_busy,
    output host_ready, Host_Config, cfg_update, fill_idx, cfg_count
  );

endinterface

// File: rtl/host_config_loader_cfg_shadow_reg.sv
// Shadow register written one word slot at a time; bits of the last slot
// beyond the configuration width are dropped.
module cfg_shadow_reg #(
  parameter int unsigned H_C_W     = 80,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [H_C_W-1:0]  shadow
);
  localparam int unsigned WideW = NUM_WORDS * DATA_W;

  logic [H_C_W-1:0] shadow_q, shadow_d;
  logic [WideW-1:0] wide;

  // Write into a slot-aligned view, then keep only the configuration bits.
  always_comb begin
    wide = '0;
    wide[H_C_W-1:0] = shadow_q;
    if (we) begin
      wide[int'(idx) * DATA_W +: DATA_W] = wdata;
    end
    shadow_d = wide[H_C_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/host_config_loader.sv
// Word-serial configuration loader: fills a shadow frame, then commits it to
// Host_Config in one cycle once the array is idle.
module host_config_loader
  import host_config_loader_pkg::*;
#(
  parameter int unsigned H_C_W  = HCfgWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  localparam int unsigned NUM_WORDS = num_words(H_C_W, DATA_W),
  localparam int unsigned IDX_W     = idx_width(NUM_WORDS)
) (
  input logic clk,
  input logic rst,
  host_config_loader_if.slave bus
);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [H_C_W-1:0] cfg_q;
  logic [H_C_W-1:0] shadow;
  logic [15:0]      cfg_count_q;
  logic             cfg_update_q;
  logic             ready;
  logic             xfer;
  logic             commit;

  assign ready = (state_q == StFill) && !bus.host_abort && !rst;
  assign xfer  = bus.host_valid && ready;

  cfg_shadow_reg #(
    .H_C_W    (H_C_W),
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer),
    .idx   (fill_idx_q),
    .wdata (bus.host_data),
    .shadow(shadow)
  );

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    commit     = 1'b0;
    unique case (state_q)
      StFill: begin
        if (bus.host_abort) begin
          fill_idx_d = '0;
        end else if (xfer) begin
          if (fill_idx_q == LastIdx) begin
            fill_idx_d = '0;
            state_d    = StPend;
          end else begin
            fill_idx_d = fill_idx_q + 1'b1;
          end
        end
      end
      StPend: begin
        // Abort wins over a commit that would otherwise happen this cycle.
        if (bus.host_abort) begin
          state_d = StFill;
        end else if (!bus.array_busy) begin
          commit  = 1'b1;
          state_d = StFill;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      fill_idx_q   <= '0;
      cfg_q        <= '0;
      cfg_update_q <= 1'b0;
      cfg_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      cfg_update_q <= commit;
      if (commit) begin
        cfg_q       <= shadow;
        cfg_count_q <= cfg_count_q + 16'd1;
      end
    end
  end

  assign bus.host_ready  = ready;
  assign bus.Host_Config = cfg_q;
  assign bus.cfg_update  = cfg_update_q;
  assign bus.fill_idx    = fill_idx_q;
  assign bus.cfg_count   = cfg_count_q;

endmodule

// File: tb/tb_host_config_loader.sv
// Directed and random checks of host_config_loader against a frame-level queue model.
module tb_host_config_loader;
  localparam int unsigned CW = 80;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 3;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model: words collected so far; a full queue means a frame awaits commit.
  logic [DW-1:0] q[$];
  logic [CW-1:0] m_cfg;
  logic          m_upd;
  logic [15:0]   m_cnt;

  host_config_loader_if #(.H_C_W(CW), .DATA_W(DW)) bus ();

  host_config_loader #(.H_C_W(CW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack_frame();
    logic [NW*DW-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w[i*DW +: DW] = q[i];
    return w[CW-1:0];
  endfunction

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic ab,
                            input logic bz, input logic r);
    m_upd = 1'b0;
    if (r) begin
      q.delete();
      m_cfg = '0;
      m_cnt = '0;
    end else if (q.size() == NW) begin
      if (ab) begin
        q.delete();
      end else if (!bz) begin
        m_cfg = pack_frame();
        m_cnt = m_cnt + 16'd1;
        m_upd = 1'b1;
        q.delete();
      end
    end else if (ab) begin
      q.delete();
    end else if (v) begin
      q.push_back(d);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational ready, then the registered outputs.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ab,
                     input logic bz, input logic r);
    logic exp_ready;
    bus.host_valid = v;
    bus.host_data  = d;
    bus.host_abort = ab;
    bus.array_busy = bz;
    rst            = r;
    exp_ready      = !r && !ab && (q.size() < NW);
    #1;
    chk("host_ready", CW'(bus.host_ready), CW'(exp_ready));
    @(posedge clk);
    model_step(v, d, ab, bz, r);
    #1;
    chk("Host_Config", bus.Host_Config, m_cfg);
    chk("cfg_update", CW'(bus.cfg_update), CW'(m_upd));
    chk("cfg_count", CW'(bus.cfg_count), CW'(m_cnt));
    chk("fill_idx", CW'(bus.fill_idx), CW'(q.size() % NW));
  endtask

  task automatic word(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic bz);
    cyc(1'b0, '0, 1'b0, bz, 1'b0);
  endtask

  initial begin
    m_cfg = '0;
    m_upd = 1'b0;
    m_cnt = '0;
    rst = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.host_abort = 1'b0;
    bus.array_busy = 1'b0;

    repeat (3) cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    chk("reset_cfg", bus.Host_Config, '0);

    // Basic back-to-back frame
    word(32'h1111_1111); word(32'h2222_2222); word(32'hAAAA_3333);
    idle(1'b0);
    chk("basic_cfg", bus.Host_Config, 80'h3333_2222_2222_1111_1111);
    chk("basic_upd", CW'(bus.cfg_update), CW'(1'b1));
    idle(1'b0);
    chk("basic_upd_drop", CW'(bus.cfg_update), '0);

    // Busy holds the commit for five cycles
    word(32'h0A0B_0C0D); word(32'h1234_5678); word(32'h9ABC_DEF0);
    repeat (5) idle(1'b1);
    chk("busy_hold_cfg", bus.Host_Config, 80'h3333_2222_2222_1111_1111);
    idle(1'b0);
    chk("busy_commit_cfg", bus.Host_Config, 80'hDEF0_1234_5678_0A0B_0C0D);
    chk("busy_count", CW'(bus.cfg_count), CW'(16'd2));

    // Abort mid-frame, word offered during abort is dropped
    word(32'hDEAD_BEEF); word(32'hCAFE_F00D);
    cyc(1'b1, 32'h5555_5555, 1'b1, 1'b0, 1'b0);
    word(32'h1); word(32'h2); word(32'h3);
    idle(1'b0);
    chk("abort_fill_cfg", bus.Host_Config, 80'h0003_0000_0002_0000_0001);
    chk("abort_fill_count", CW'(bus.cfg_count), CW'(16'd3));

    // Abort in PEND beats a same-cycle commit
    word(32'h7777_7777); word(32'h8888_8888); word(32'h9999_9999);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("abort_pend_upd", CW'(bus.cfg_update), '0);
    chk("abort_pend_cfg", bus.Host_Config, 80'h0003_0000_0002_0000_0001);
    idle(1'b0);

    // Reset mid-frame, then a clean frame
    word(32'h4444_4444); word(32'h5555_5555);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_cfg", bus.Host_Config, '0);
    word(32'hA1A1_A1A1); word(32'hB2B2_B2B2); word(32'h0000_C3C3);
    idle(1'b0);
    chk("post_rst_cfg", bus.Host_Config, 80'hC3C3_B2B2_B2B2_A1A1_A1A1);

    // Counter wrap from 0xFFFF
    force dut.cfg_count_q = 16'hFFFF;
    #1;
    release dut.cfg_count_q;
    m_cnt = 16'hFFFF;
    idle(1'b0);
    word(32'h1); word(32'h2); word(32'h3);
    idle(1'b0);
    chk("wrap_count", CW'(bus.cfg_count), '0);

    // Random traffic with gaps, busy, aborts and the odd reset
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
